// File: rtl/sample_memory_controller.sv
// Record/playback sequencer and sole master of the 64K x 16 sample memory bank.
// Latency: a write lands 1 cycle after its sample strobe; play_tick -> sample_out_valid is 3 cycles.
// Backpressure: none; play ticks arriving while a read is in flight are dropped, not queued.
module sample_memory_controller #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter bit LOOP   = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_record,
    input  logic              start_play,
    input  logic              stop,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] sample_in,
    input  logic              play_tick,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_datain,
    input  logic [DATA_W-1:0] mem_dataout,
    output logic [DATA_W-1:0] sample_out,
    output logic              sample_out_valid,
    output logic              recording,
    output logic              playing,
    output logic [ADDR_W:0]   rec_length
);

    typedef enum logic [2:0] {
        IDLE,
        RECORD,
        PLAY_WAIT,
        PLAY_ADDR,
        PLAY_DATA
    } state_t;

    // rec_length doubles as the write pointer: the next free address is the sample count.
    localparam logic [ADDR_W:0] LAST_ADDR = {1'b0, {ADDR_W{1'b1}}};

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   rd_ptr, rd_ptr_nxt;
    logic [ADDR_W-1:0]   address_nxt;
    logic                write_nxt;
    logic [DATA_W-1:0]   datain_nxt;
    logic [DATA_W-1:0]   sample_nxt;
    logic                valid_nxt;
    logic [ADDR_W:0]     length_nxt;
    logic [ADDR_W:0]     last_index;
    logic                at_last;

    assign last_index = rec_length - {{ADDR_W{1'b0}}, 1'b1};
    assign at_last    = ({1'b0, rd_ptr} == last_index);

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and next-output decode; every output below is registered from these.
    always_comb begin
        state_nxt   = state;
        rd_ptr_nxt  = rd_ptr;
        address_nxt = mem_address;
        write_nxt   = 1'b0;
        datain_nxt  = mem_datain;
        sample_nxt  = sample_out;
        valid_nxt   = 1'b0;
        length_nxt  = rec_length;
        case (state)
            IDLE: begin
                if (start_record) begin
                    state_nxt  = RECORD;
                    length_nxt = '0;
                end else if (start_play && (rec_length != '0)) begin
                    state_nxt  = PLAY_WAIT;
                    rd_ptr_nxt = '0;
                end
            end
            RECORD: begin
                // A sample strobed alongside stop is still written and counted.
                if (sample_valid) begin
                    write_nxt   = 1'b1;
                    address_nxt = rec_length[ADDR_W-1:0];
                    datain_nxt  = sample_in;
                    length_nxt  = rec_length + {{ADDR_W{1'b0}}, 1'b1};
                    if (rec_length == LAST_ADDR) begin
                        state_nxt = IDLE;
                    end
                end
                if (stop) begin
                    state_nxt = IDLE;
                end
            end
            PLAY_WAIT: begin
                if (stop) begin
                    state_nxt = IDLE;
                end else if (play_tick) begin
                    state_nxt   = PLAY_ADDR;
                    address_nxt = rd_ptr;
                end
            end
            PLAY_ADDR: begin
                state_nxt = stop ? IDLE : PLAY_DATA;
            end
            PLAY_DATA: begin
                // stop abandons the read here, so no valid pulse is produced.
                if (stop) begin
                    state_nxt = IDLE;
                end else begin
                    sample_nxt = mem_dataout;
                    valid_nxt  = 1'b1;
                    rd_ptr_nxt = rd_ptr + {{(ADDR_W-1){1'b0}}, 1'b1};
                    if (at_last) begin
                        if (LOOP) begin
                            rd_ptr_nxt = '0;
                            state_nxt  = PLAY_WAIT;
                        end else begin
                            state_nxt  = IDLE;
                        end
                    end else begin
                        state_nxt = PLAY_WAIT;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Datapath and status registers; status flags track the state they accompany.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr           <= '0;
            mem_address      <= '0;
            mem_write        <= 1'b0;
            mem_datain       <= '0;
            sample_out       <= '0;
            sample_out_valid <= 1'b0;
            rec_length       <= '0;
            recording        <= 1'b0;
            playing          <= 1'b0;
        end else begin
            rd_ptr           <= rd_ptr_nxt;
            mem_address      <= address_nxt;
            mem_write        <= write_nxt;
            mem_datain       <= datain_nxt;
            sample_out       <= sample_nxt;
            sample_out_valid <= valid_nxt;
            rec_length       <= length_nxt;
            recording        <= (state_nxt == RECORD);
            playing          <= (state_nxt == PLAY_WAIT) || (state_nxt == PLAY_ADDR) ||
                                (state_nxt == PLAY_DATA);
        end
    end

endmodule
